// File: rtl/router_input_buffer.sv
// router_input_buffer
// Router input stage: one FIFO per virtual channel, plus a per-VC
// head/body/tail framing checker. Flits that break packet framing are
// consumed but not stored, and a sticky error flag is raised for that VC.
// Each VC presents its head-of-line flit to the downstream stage with a
// one-cycle write-to-read latency.

module router_input_buffer #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VC       = 2,
  parameter int BUFF_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      arst,
  input  logic                                      in_valid,
  input  logic [((N_VC > 1) ? $clog2(N_VC) : 1)-1:0] in_vc,
  input  logic [FLIT_WIDTH-1:0]                     in_fdata,
  output logic [N_VC-1:0]                           in_ready,
  output logic [N_VC-1:0]                           out_valid,
  output logic [N_VC*FLIT_WIDTH-1:0]                out_fdata,
  input  logic [N_VC-1:0]                           out_ready,
  output logic [N_VC-1:0]                           pkt_active,
  output logic [N_VC-1:0]                           err_proto
);

  localparam int VC_W  = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int PTR_W = $clog2(BUFF_DEPTH);

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  // Flit type lives in the top two bits of the flit.
  logic [1:0] in_type;
  assign in_type = in_fdata[FLIT_WIDTH-1 -: 2];

  // VC ids beyond N_VC select nothing, so such flits are silently ignored.
  logic vc_ok;
  assign vc_ok = ({1'b0, in_vc} < (VC_W+1)'(N_VC));

  genvar gi;
  generate
    for (gi = 0; gi < N_VC; gi++) begin : g_vc
      pkt_state_t            state_reg;
      pkt_state_t            state_next;
      logic [PTR_W:0]        wr_ptr_reg;
      logic [PTR_W:0]        wr_ptr_next;
      logic [PTR_W:0]        rd_ptr_reg;
      logic [PTR_W:0]        rd_ptr_next;
      logic                  err_reg;
      logic                  err_next;
      logic [FLIT_WIDTH-1:0] mem [BUFF_DEPTH];
      logic                  full;
      logic                  empty;
      logic                  accept;
      logic                  store;
      logic                  drop;
      logic                  pop;
      logic [PTR_W-1:0]      rd_idx;

      // Extra pointer MSB distinguishes full from empty when low bits match.
      assign full   = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                      (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
      assign empty  = (wr_ptr_reg == rd_ptr_reg);

      // Handshake depends only on registered fullness; dropped flits still complete.
      assign accept = in_valid && vc_ok && (in_vc == VC_W'(gi)) && !full;
      assign pop    = !empty && out_ready[gi];

      // Framing state register
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          state_reg <= ST_IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // Framing next-state: only legal flits move the state
      always_comb begin
        state_next = state_reg;
        if (accept) begin
          case (state_reg)
            ST_IDLE:   if (in_type == FT_HEAD) state_next = ST_IN_PKT;
            ST_IN_PKT: if (in_type == FT_TAIL) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
          endcase
        end
      end

      // Framing outputs: decide whether an accepted flit is stored or dropped
      always_comb begin
        store = 1'b0;
        drop  = 1'b0;
        if (accept) begin
          case (state_reg)
            ST_IDLE:   store = (in_type == FT_HEAD) || (in_type == FT_HT);
            ST_IN_PKT: store = (in_type == FT_BODY) || (in_type == FT_TAIL);
            default:   store = 1'b0;
          endcase
          drop = !store;
        end
      end

      assign wr_ptr_next = wr_ptr_reg + (PTR_W+1)'(store);
      assign rd_ptr_next = rd_ptr_reg + (PTR_W+1)'(pop);
      assign err_next    = err_reg | drop;

      // Pointers and sticky error flag
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          err_reg    <= 1'b0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          err_reg    <= err_next;
        end
      end

      // Flit storage; contents survive reset on purpose
      always_ff @(posedge clk) begin
        if (store) begin
          mem[wr_ptr_reg[PTR_W-1:0]] <= in_fdata;
        end
      end

      // When empty, show the most recently stored slot rather than a stale one.
      assign rd_idx = empty ? (rd_ptr_reg[PTR_W-1:0] - PTR_W'(1)) : rd_ptr_reg[PTR_W-1:0];

      assign out_fdata[gi*FLIT_WIDTH +: FLIT_WIDTH] = mem[rd_idx];
      assign out_valid[gi]  = !empty;
      assign in_ready[gi]   = !full;
      assign pkt_active[gi] = (state_reg == ST_IN_PKT);
      assign err_proto[gi]  = err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_router_input_buffer.sv
// tb_router_input_buffer
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the buffer and its framing rules.

module tb_router_input_buffer;

  localparam int FW = 34;
  localparam int NV = 2;
  localparam int D  = 4;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid;
  logic [0:0]    in_vc;
  logic [FW-1:0] in_fdata;
  logic [NV-1:0] in_ready;
  logic [NV-1:0] out_valid;
  logic [NV*FW-1:0] out_fdata;
  logic [NV-1:0] out_ready;
  logic [NV-1:0] pkt_active;
  logic [NV-1:0] err_proto;

  int checks   = 0;
  int failures = 0;

  // Model: contents of each VC buffer, whether a packet is open, sticky error.
  logic [FW-1:0] mq [NV][$];
  logic [NV-1:0] m_inpkt;
  logic [NV-1:0] m_err;

  router_input_buffer #(.FLIT_WIDTH(FW), .N_VC(NV), .BUFF_DEPTH(D)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_vc(in_vc),
    .in_fdata(in_fdata), .in_ready(in_ready), .out_valid(out_valid),
    .out_fdata(out_fdata), .out_ready(out_ready), .pkt_active(pkt_active),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] vcd(input int v);
    return out_fdata[v*FW +: FW];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_inpkt = '0;
    m_err   = '0;
  endtask

  // Every DUT output against the model, once per cycle.
  task automatic compare_all();
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("out_valid[%0d]", v), 64'(out_valid[v]), 64'(mq[v].size() != 0));
      chk($sformatf("in_ready[%0d]", v), 64'(in_ready[v]), 64'(mq[v].size() < D));
      chk($sformatf("pkt_active[%0d]", v), 64'(pkt_active[v]), 64'(m_inpkt[v]));
      chk($sformatf("err_proto[%0d]", v), 64'(err_proto[v]), 64'(m_err[v]));
      if (mq[v].size() != 0)
        chk($sformatf("out_fdata[%0d]", v), 64'(vcd(v)), 64'(mq[v][0]));
    end
  endtask

  // Advance the model by the clock edge that will consume the current inputs.
  task automatic model_step();
    logic [NV-1:0] popv;
    int            vc;
    logic [1:0]    ft;
    logic          starts;
    if (arst) begin
      model_reset();
      return;
    end
    for (int v = 0; v < NV; v++) popv[v] = (mq[v].size() != 0) && out_ready[v];
    vc = int'(in_vc);
    if (in_valid && vc < NV && mq[vc].size() < D) begin
      ft     = in_fdata[FW-1 -: 2];
      starts = (ft == HEAD) || (ft == HT);
      // A packet-starting flit is legal exactly when no packet is open.
      if (starts != m_inpkt[vc]) begin
        mq[vc].push_back(in_fdata);
        m_inpkt[vc] = (ft == HEAD) || (ft == BODY);
        $display("accept vc=%0d flit=%h", vc, in_fdata);
      end else begin
        m_err[vc] = 1'b1;
        $display("drop   vc=%0d flit=%h", vc, in_fdata);
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (popv[v]) begin
        $display("pop    vc=%0d flit=%h", v, mq[v][0]);
        void'(mq[v].pop_front());
      end
    end
  endtask

  // One clock cycle: check, then drive inputs for the next rising edge.
  task automatic cyc(input logic v, input int vc, input logic [1:0] t,
                     input logic [31:0] pl, input logic [NV-1:0] ordy);
    @(negedge clk);
    compare_all();
    #1;
    in_valid  = v;
    in_vc     = vc[0];
    in_fdata  = {t, pl};
    out_ready = ordy;
    model_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] t;
    int         vc;
    arst      = 1'b1;
    in_valid  = 1'b0;
    in_vc     = '0;
    in_fdata  = '0;
    out_ready = '0;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) cyc(0, 0, HEAD, 0, 2'b00);
    after_edge();
    chk("rst in_ready", 64'(in_ready), 64'(2'b11));
    chk("rst out_valid", 64'(out_valid), 64'(2'b00));
    chk("rst pkt_active", 64'(pkt_active), 64'(2'b00));
    chk("rst err_proto", 64'(err_proto), 64'(2'b00));
    arst = 1'b0;

    // Fill and drain VC0
    cyc(1, 0, HEAD, 32'hA0, 2'b00);
    after_edge();
    chk("fill pkt_active0 after head", 64'(pkt_active[0]), 64'd1);
    chk("fill out_valid0 after head", 64'(out_valid[0]), 64'd1);
    cyc(1, 0, BODY, 32'hA1, 2'b00);
    cyc(1, 0, BODY, 32'hA2, 2'b00);
    cyc(1, 0, TAIL, 32'hA3, 2'b00);
    after_edge();
    chk("fill in_ready full", 64'(in_ready), 64'(2'b10));
    chk("fill pkt_active0 after tail", 64'(pkt_active[0]), 64'd0);
    chk("fill head data", 64'(vcd(0)), 64'({HEAD, 32'hA0}));
    cyc(0, 0, HEAD, 0, 2'b01);
    after_edge();
    chk("drain second flit", 64'(vcd(0)), 64'({BODY, 32'hA1}));
    for (int i = 0; i < 3; i++) cyc(0, 0, HEAD, 0, 2'b01);
    after_edge();
    chk("drain empty", 64'(out_valid[0]), 64'd0);
    chk("drain in_ready", 64'(in_ready), 64'(2'b11));

    // Streaming across pointer wrap on VC1
    for (int i = 0; i < 10; i++) begin
      t = (i == 0) ? HEAD : ((i == 9) ? TAIL : BODY);
      cyc(1, 1, t, 32'hB00 + i, 2'b10);
      after_edge();
      chk($sformatf("stream out_valid1 #%0d", i), 64'(out_valid[1]), 64'd1);
      chk($sformatf("stream data #%0d", i), 64'(vcd(1)), 64'({t, 32'hB00 + i}));
      chk($sformatf("stream in_ready1 #%0d", i), 64'(in_ready[1]), 64'd1);
    end
    cyc(0, 1, HEAD, 0, 2'b10);
    after_edge();
    chk("stream drained", 64'(out_valid[1]), 64'd0);

    // Framing errors on VC0
    cyc(1, 0, BODY, 32'hC0, 2'b00);
    after_edge();
    chk("frame body in idle err", 64'(err_proto[0]), 64'd1);
    chk("frame body dropped", 64'(out_valid[0]), 64'd0);
    cyc(1, 0, HEAD, 32'hC1, 2'b00);
    cyc(1, 0, HEAD, 32'hC2, 2'b00);
    after_edge();
    chk("frame err sticky", 64'(err_proto), 64'(2'b01));
    chk("frame pkt_active0", 64'(pkt_active[0]), 64'd1);
    chk("frame first head kept", 64'(vcd(0)), 64'({HEAD, 32'hC1}));
    cyc(1, 0, TAIL, 32'hC3, 2'b00);
    cyc(0, 0, HEAD, 0, 2'b01);
    cyc(0, 0, HEAD, 0, 2'b01);

    // Full VC0 with simultaneous write and pop
    cyc(1, 0, HEAD, 32'hD0, 2'b00);
    cyc(1, 0, BODY, 32'hD1, 2'b00);
    cyc(1, 0, BODY, 32'hD2, 2'b00);
    cyc(1, 0, BODY, 32'hD3, 2'b00);
    after_edge();
    chk("full in_ready0", 64'(in_ready[0]), 64'd0);
    cyc(1, 0, BODY, 32'hD4, 2'b01);
    after_edge();
    chk("full pop freed slot", 64'(in_ready[0]), 64'd1);
    chk("full head after pop", 64'(vcd(0)), 64'({BODY, 32'hD1}));
    cyc(1, 0, TAIL, 32'hD5, 2'b00);
    after_edge();
    chk("full refilled", 64'(in_ready[0]), 64'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, HEAD, 0, 2'b01);
    after_edge();
    chk("full drained", 64'(out_valid[0]), 64'd0);

    // Reset mid-packet on VC1
    cyc(1, 1, HEAD, 32'hE0, 2'b00);
    cyc(1, 1, BODY, 32'hE1, 2'b00);
    after_edge();
    chk("midrst pkt_active1", 64'(pkt_active[1]), 64'd1);
    chk("midrst out_valid1", 64'(out_valid[1]), 64'd1);
    @(negedge clk);
    compare_all();
    #1;
    in_valid  = 1'b0;
    out_ready = 2'b00;
    #1 arst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'(2'b00));
    chk("midrst pkt_active", 64'(pkt_active), 64'(2'b00));
    chk("midrst err_proto", 64'(err_proto), 64'(2'b00));
    chk("midrst in_ready", 64'(in_ready), 64'(2'b11));
    arst = 1'b0;
    model_reset();
    model_step();
    cyc(1, 1, BODY, 32'hE2, 2'b00);
    after_edge();
    chk("midrst body err", 64'(err_proto[1]), 64'd1);
    chk("midrst body dropped", 64'(out_valid[1]), 64'd0);

    // Single-flit packet on VC0
    cyc(1, 0, HT, 32'hF0, 2'b00);
    after_edge();
    chk("ht pkt_active0", 64'(pkt_active[0]), 64'd0);
    chk("ht stored", 64'(out_valid[0]), 64'd1);
    chk("ht data", 64'(vcd(0)), 64'({HT, 32'hF0}));
    cyc(0, 0, HEAD, 0, 2'b01);
    after_edge();
    chk("ht popped", 64'(out_valid[0]), 64'd0);

    // Randomized traffic, mostly legal framing
    for (int i = 0; i < 600; i++) begin
      vc = int'($urandom_range(0, NV - 1));
      if ($urandom_range(0, 99) < 85) begin
        if (m_inpkt[vc]) t = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
        else             t = ($urandom_range(0, 3) == 0) ? HT : HEAD;
      end else begin
        t = 2'($urandom_range(0, 3));
      end
      cyc(($urandom_range(0, 99) < 70), vc, t, $urandom,
          {($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60)});
    end
    for (int i = 0; i < D + 1; i++) cyc(0, 0, HEAD, 0, 2'b11);
    @(negedge clk);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
